// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the alu_pipe block.
package alu_pkg;

  localparam int OPERATOR_LEN = 4;

  localparam logic [OPERATOR_LEN-1:0] OPERATOR_ADD  = 4'd0;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SUB  = 4'd1;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_AND  = 4'd2;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_OR   = 4'd3;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_NOR  = 4'd4;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_XOR  = 4'd5;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SLL  = 4'd6;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SRL  = 4'd7;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SRA  = 4'd8;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SLT  = 4'd9;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_SLTU = 4'd10;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_MUL  = 4'd11;
  localparam logic [OPERATOR_LEN-1:0] OPERATOR_NOP  = 4'd15;

  localparam int FLAGS_LEN = 5;
  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_E    = 4;

  localparam logic [0:0] STATE_IDLE     = 1'b0;
  localparam logic [0:0] STATE_MUL_BUSY = 1'b1;

  function automatic logic [FLAGS_LEN-1:0] pack_flags(input logic e, input logic v,
                                                      input logic c, input logic n,
                                                      input logic z);
    logic [FLAGS_LEN-1:0] f;
    f         = '0;
    f[FLAG_E] = e;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WORD_LEN steps.
module alu_mul_seq #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_LEN-1:0] operand1,
  input  logic [WORD_LEN-1:0] operand2,
  output logic                done,
  output logic [WORD_LEN-1:0] product
);

  localparam int CNT_LEN = $clog2(WORD_LEN) + 1;

  logic [WORD_LEN-1:0] acc_d, acc_q;
  logic [WORD_LEN-1:0] mcand_d, mcand_q;
  logic [WORD_LEN-1:0] mplier_d, mplier_q;
  logic [CNT_LEN-1:0]  cnt_d, cnt_q;
  logic [WORD_LEN-1:0] step_s;

  // product is the accumulator after the current step, so the final step's sum is usable directly
  always_comb begin
    step_s   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = operand1;
      mplier_d = operand2;
      cnt_d    = CNT_LEN'(WORD_LEN);
    end else if (cnt_q != '0) begin
      acc_d    = step_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_LEN'(1);
    end else begin
      acc_d    = acc_q;
    end
  end

  assign done    = (cnt_q == CNT_LEN'(1));
  assign product = step_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ALU with registered result/flags and valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative multiplier; without it MUL is an unrecognised opcode.
module alu_pipe #(
  parameter int WORD_LEN     = 32,
  parameter int OPERATOR_LEN = alu_pkg::OPERATOR_LEN
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [WORD_LEN-1:0]     OPERAND1,
  input  logic [WORD_LEN-1:0]     OPERAND2,
  input  logic [OPERATOR_LEN-1:0] OPERATOR,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [WORD_LEN-1:0]     ALU_OUT,
  output logic [4:0]              FLAGS
);

  import alu_pkg::*;

  localparam int SHIFT_LEN = $clog2(WORD_LEN);

  logic [WORD_LEN:0]    sum_s;
  logic [WORD_LEN:0]    diff_s;
  logic [WORD_LEN-1:0]  res_s;
  logic                 c_s;
  logic                 v_s;
  logic                 e_s;
  logic [SHIFT_LEN-1:0] shamt_s;
  logic                 idle_s;
  logic                 in_ready_s;
  logic                 handshake_s;

  logic                 out_valid_d, out_valid_q;
  logic [WORD_LEN-1:0]  alu_out_d, alu_out_q;
  logic [4:0]           flags_d, flags_q;

`ifdef ALU_MUL_EN
  logic [0:0]           state_d, state_q;
  logic                 is_mul_s;
  logic                 mul_start_s;
  logic                 mul_seq_done_s;
  logic                 mul_done_s;
  logic [WORD_LEN-1:0]  mul_product_s;

  alu_mul_seq #(
    .WORD_LEN (WORD_LEN)
  ) u_mul_seq (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (mul_start_s),
    .operand1 (OPERAND1),
    .operand2 (OPERAND2),
    .done     (mul_seq_done_s),
    .product  (mul_product_s)
  );

  assign is_mul_s   = (OPERATOR == OPERATOR_LEN'(OPERATOR_MUL));
  assign mul_done_s = (state_q == STATE_MUL_BUSY) && mul_seq_done_s;
  assign idle_s     = (state_q == STATE_IDLE);
`else
  assign idle_s     = 1'b1;
`endif

  assign in_ready_s  = idle_s && (!out_valid_q || OUT_READY);
  assign handshake_s = IN_VALID && in_ready_s;
  assign shamt_s     = OPERAND2[SHIFT_LEN-1:0];

  // Single-cycle datapath; the borrow of SUB falls out as the extra MSB of the difference
  always_comb begin
    sum_s  = {1'b0, OPERAND1} + {1'b0, OPERAND2};
    diff_s = {1'b0, OPERAND1} - {1'b0, OPERAND2};
    res_s  = '0;
    c_s    = 1'b0;
    v_s    = 1'b0;
    e_s    = 1'b0;
    case (OPERATOR)
      OPERATOR_LEN'(OPERATOR_ADD): begin
        res_s = sum_s[WORD_LEN-1:0];
        c_s   = sum_s[WORD_LEN];
        v_s   = (OPERAND1[WORD_LEN-1] == OPERAND2[WORD_LEN-1]) &&
                (sum_s[WORD_LEN-1] != OPERAND1[WORD_LEN-1]);
      end
      OPERATOR_LEN'(OPERATOR_SUB): begin
        res_s = diff_s[WORD_LEN-1:0];
        c_s   = diff_s[WORD_LEN];
        v_s   = (OPERAND1[WORD_LEN-1] != OPERAND2[WORD_LEN-1]) &&
                (diff_s[WORD_LEN-1] != OPERAND1[WORD_LEN-1]);
      end
      OPERATOR_LEN'(OPERATOR_AND):  res_s = OPERAND1 & OPERAND2;
      OPERATOR_LEN'(OPERATOR_OR):   res_s = OPERAND1 | OPERAND2;
      OPERATOR_LEN'(OPERATOR_NOR):  res_s = ~(OPERAND1 | OPERAND2);
      OPERATOR_LEN'(OPERATOR_XOR):  res_s = OPERAND1 ^ OPERAND2;
      OPERATOR_LEN'(OPERATOR_SLL):  res_s = OPERAND1 << shamt_s;
      OPERATOR_LEN'(OPERATOR_SRL):  res_s = OPERAND1 >> shamt_s;
      OPERATOR_LEN'(OPERATOR_SRA):  res_s = $unsigned($signed(OPERAND1) >>> shamt_s);
      OPERATOR_LEN'(OPERATOR_SLT):  res_s = WORD_LEN'($signed(OPERAND1) < $signed(OPERAND2));
      OPERATOR_LEN'(OPERATOR_SLTU): res_s = WORD_LEN'(OPERAND1 < OPERAND2);
`ifdef ALU_MUL_EN
      OPERATOR_LEN'(OPERATOR_MUL):  res_s = '0;
`endif
      OPERATOR_LEN'(OPERATOR_NOP):  res_s = '0;
      default: begin
        res_s = '0;
        e_s   = 1'b1;
      end
    endcase
  end

  // Output register and FSM next-state: a multiply completion wins, then a new request, then draining
  always_comb begin
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
`ifdef ALU_MUL_EN
    state_d     = state_q;
    mul_start_s = 1'b0;
    if (mul_done_s) begin
      out_valid_d = 1'b1;
      alu_out_d   = mul_product_s;
      flags_d     = pack_flags(1'b0, 1'b0, 1'b0, mul_product_s[WORD_LEN-1],
                               mul_product_s == '0);
      state_d     = STATE_IDLE;
    end else if (handshake_s && is_mul_s) begin
      out_valid_d = 1'b0;
      mul_start_s = 1'b1;
      state_d     = STATE_MUL_BUSY;
    end else
`endif
    if (handshake_s) begin
      out_valid_d = 1'b1;
      alu_out_d   = res_s;
      flags_d     = pack_flags(e_s, v_s, c_s, res_s[WORD_LEN-1], res_s == '0);
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= 5'b00000;
`ifdef ALU_MUL_EN
      state_q     <= STATE_IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = alu_out_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus random traffic against a transaction-level model.
module tb_alu_pipe;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] OPERAND1 = '0;
  logic [W-1:0] OPERAND2 = '0;
  logic [3:0]   OPERATOR = 4'd0;
  logic         IN_READY;
  logic         OUT_VALID;
  logic [W-1:0] ALU_OUT;
  logic [4:0]   FLAGS;

  int checks = 0;
  int errors = 0;

  // Model: the expected contents of the output register, plus cycles left on a pending multiply
  bit           m_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic [4:0]   m_flags = '0;
  int           m_busy = 0;
  logic [W-1:0] m_pend_res = '0;
  logic [4:0]   m_pend_flags = '0;

  alu_pipe #(.WORD_LEN(W), .OPERATOR_LEN(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OPERAND1  (OPERAND1),
    .OPERAND2  (OPERAND2),
    .OPERATOR  (OPERATOR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ALU_OUT   (ALU_OUT),
    .FLAGS     (FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [4:0] f);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          smax = 64'sd2147483647;
    longint          smin = -64'sd2147483648;
    int              sh = int'(b % 32);
    logic            c = 1'b0;
    logic            v = 1'b0;
    logic            e = 1'b0;
    r = '0;
    case (op)
      4'd0: begin r = W'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; v = (sa + sb > smax) || (sa + sb < smin); end
      4'd1: begin r = W'(ua - ub); c = ua < ub; v = (sa - sb > smax) || (sa - sb < smin); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~(a | b);
      4'd5: r = a ^ b;
      4'd6: r = W'(ua << sh);
      4'd7: r = W'(ua >> sh);
      4'd8: r = W'(sa >>> sh);
      4'd9: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd11: if (MUL_EN) r = W'(ua * ub); else e = 1'b1;
      4'd15: r = '0;
      default: e = 1'b1;
    endcase
    f = {e, v, c, r[W-1], (r == 0)};
  endfunction

  // One clock cycle: drive, compare with the model, advance the model past the coming edge
  task automatic step(input bit iv, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit ordy);
    bit           exp_ready;
    logic [W-1:0] r;
    logic [4:0]   f;
    IN_VALID = iv; OPERATOR = op; OPERAND1 = a; OPERAND2 = b; OUT_READY = ordy;
    #1;
    exp_ready = (m_busy == 0) && (!m_valid || ordy);
    check_eq("in_ready", IN_READY, exp_ready);
    check_eq("out_valid", OUT_VALID, m_valid);
    if (m_valid) begin
      check_eq("alu_out", ALU_OUT, m_res);
      check_eq("flags", FLAGS, m_flags);
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1; m_res = m_pend_res; m_flags = m_pend_flags;
      end
    end else if (iv && exp_ready) begin
      ref_alu(op, a, b, r, f);
      if (MUL_EN && op == 4'd11) begin
        m_valid = 1'b0; m_busy = W; m_pend_res = r; m_pend_flags = f;
      end else begin
        m_valid = 1'b1; m_res = r; m_flags = f;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    IN_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    check_eq("rst_out_valid", OUT_VALID, 1'b0);
    check_eq("rst_alu_out", ALU_OUT, 64'h0);
    check_eq("rst_flags", FLAGS, 64'h0);
    #2;
    RST_N = 1'b1;
    m_valid = 1'b0;
    m_busy = 0;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_out_valid", OUT_VALID, 1'b0);
    check_eq("reset_alu_out", ALU_OUT, 64'h0);
    check_eq("reset_flags", FLAGS, 64'h0);
    RST_N = 1'b1;

    step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check_eq("add_latency", OUT_VALID, 1'b1);
    check_eq("add_wrap_out", ALU_OUT, 64'h0);
    check_eq("add_wrap_flags", FLAGS, 64'h05);
    step(1'b1, 4'd1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    check_eq("sub_ovf_out", ALU_OUT, 64'h7FFF_FFFF);
    check_eq("sub_ovf_flags", FLAGS, 64'h08);
    step(1'b1, 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check_eq("slt_out", ALU_OUT, 64'h1);
    step(1'b1, 4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check_eq("sltu_out", ALU_OUT, 64'h0);
    check_eq("sltu_flags", FLAGS, 64'h01);
    step(1'b1, 4'd8, 32'h8000_0000, 32'h0000_0024, 1'b1);
    check_eq("sra_out", ALU_OUT, 64'hF800_0000);
    check_eq("sra_flags", FLAGS, 64'h02);
    step(1'b1, 4'd7, 32'h8000_0000, 32'h0000_0024, 1'b1);
    check_eq("srl_out", ALU_OUT, 64'h0800_0000);
    step(1'b1, 4'd13, 32'h1234_5678, 32'h0000_0001, 1'b1);
    check_eq("bad_op_out", ALU_OUT, 64'h0);
    check_eq("bad_op_flags", FLAGS, 64'h11);

    // Back-pressure: first result must survive three stalled cycles, then be replaced without a bubble
    step(1'b0, 4'd0, '0, '0, 1'b1);
    step(1'b1, 4'd0, 32'd100, 32'd23, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd0, 32'd5, 32'd6, 1'b0);
      check_eq("stall_hold", ALU_OUT, 64'd123);
    end
    step(1'b1, 4'd0, 32'd5, 32'd6, 1'b1);
    check_eq("replace_valid", OUT_VALID, 1'b1);
    check_eq("replace_out", ALU_OUT, 64'd11);
    step(1'b0, 4'd0, '0, '0, 1'b1);
    check_eq("drained", OUT_VALID, 1'b0);

    step(1'b1, 4'd11, 32'd7, 32'd6, 1'b1);
`ifdef ALU_MUL_EN
    lat = 1;
    while (!OUT_VALID && lat < 40) begin
      step(1'b0, 4'd0, '0, '0, 1'b1);
      lat++;
    end
    check_eq("mul_latency", lat, 33);
    check_eq("mul_out", ALU_OUT, 64'd42);
    step(1'b0, 4'd0, '0, '0, 1'b1);
    step(1'b1, 4'd11, 32'd7, 32'd6, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 4'd0, '0, '0, 1'b1);
    pulse_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (OUT_VALID) seen++;
      step(1'b0, 4'd0, '0, '0, 1'b1);
    end
    check_eq("mul_aborted", seen, 0);
`else
    check_eq("mul_off_valid", OUT_VALID, 1'b1);
    check_eq("mul_off_out", ALU_OUT, 64'h0);
    check_eq("mul_off_flags", FLAGS, 64'h11);
    step(1'b0, 4'd0, '0, '0, 1'b1);
    pulse_reset();
`endif

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), rnd_word(), rnd_word(),
           ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 4'd0, '0, '0, 1'b1);
    pulse_reset();
    step(1'b0, 4'd0, '0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WORD_LEN, default 32, datapath width; legal values are powers of two, 8 to 64.
REQ-002 Parameter OPERATOR_LEN, default 4, opcode width.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 IN_VALID  input  1  operation request.
REQ-006 IN_READY  output  1  block can accept a request; handshake occurs when IN_VALID and IN_READY are high at a rising edge.
REQ-007 OPERAND1, OPERAND2  input  WORD_LEN each  source operands.
REQ-008 OPERATOR  input  OPERATOR_LEN  opcode.
REQ-009 OUT_VALID  output  1  ALU_OUT and FLAGS hold a valid result.
REQ-010 OUT_READY  input  1  consumer accepts the result.
REQ-011 ALU_OUT  output  WORD_LEN  registered result.
REQ-012 FLAGS  output  5  registered flags {E,V,C,N,Z}, with Z at bit 0.

Function
REQ-013 Opcodes and results:
- ADD=0: sum.
- SUB=1: difference.
- AND=2, OR=3, NOR=4, XOR=5: bitwise.
- SLL=6: logical left shift.
- SRL=7: logical right shift.
- SRA=8: arithmetic right shift.
- SLT=9: signed less-than, result 1 or 0.
- SLTU=10: unsigned less-than, result 1 or 0.
- MUL=11: low WORD_LEN bits of the product.
- NOP=15: result 0.
REQ-014 Shift amount is OPERAND2[log2(WORD_LEN)-1:0]; upper bits are ignored.
REQ-015 Flags are produced with every result:
- Z: ALU_OUT==0.
- N: ALU_OUT MSB.
- C: carry-out for ADD; borrow for SUB (OPERAND1<OPERAND2, unsigned); 0 for all other opcodes.
- V: signed overflow for ADD/SUB; 0 for all other opcodes.
- E: 1 only for an unrecognised opcode.
REQ-016 An unrecognised opcode produces ALU_OUT=0, E=1, latency 1.
REQ-017 FSM states: IDLE and MUL_BUSY.
REQ-018 IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY), derived combinationally.
REQ-019 Single-cycle ops: on handshake at edge E0, the result and flags load into the output register at E0; OUT_VALID is high in the following cycle (latency 1).
REQ-020 Throughput is one operation per cycle while OUT_READY is held high.
REQ-021 OUT_VALID falls on an edge with OUT_READY high and no new result loading at that edge.
REQ-022 While OUT_VALID && !OUT_READY, ALU_OUT and FLAGS hold stable.
REQ-023 MUL handshake: operands are captured, the FSM enters MUL_BUSY, and the iteration counter loads WORD_LEN.
REQ-024 MUL iteration: one shift-add step per cycle; on the final step the result loads, OUT_VALID rises, and the FSM returns to IDLE.
REQ-025 MUL latency is exactly WORD_LEN+1 cycles from handshake to first OUT_VALID cycle.
REQ-026 IN_READY stays low throughout MUL_BUSY.
REQ-027 A handshake that coincides with OUT_READY consumption replaces the result without a bubble.
REQ-028 Outputs are undefined-free: no X reaches ALU_OUT or FLAGS after reset.

Reset
REQ-029 RST_N low forces, immediately: state=IDLE, OUT_VALID=0, ALU_OUT=0, FLAGS=0, counter=0.
REQ-030 Reset asserted during MUL_BUSY aborts the multiply; no result is produced after reset deasserts.
REQ-031 After reset deasserts, IN_READY=1 in the first cycle.

Configuration
REQ-032 Macro ALU_MUL_EN controls the multiplier.
REQ-033 With ALU_MUL_EN defined: MUL behaves per REQ-023 to REQ-026.
REQ-034 Without ALU_MUL_EN: no multiplier logic or MUL_BUSY state is present; MUL is treated as an unrecognised opcode per REQ-016.

Structure
REQ-035 Shared package alu_pkg holds: OPERATOR_LEN, all OPERATOR_* opcode constants, FLAGS bit indices, and the FSM state encoding.
REQ-036 The iterative multiplier is a sub-module alu_mul_seq (start, operands, done, product), instantiated only under ALU_MUL_EN.

Verification (WORD_LEN=32)
REQ-037 ADD 0xFFFFFFFF + 0x00000001 -> ALU_OUT=0, Z=1, C=1, V=0; OUT_VALID one cycle after handshake.
REQ-038 SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, V=1, C=0.
REQ-038 also: SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU same operands -> 0.
REQ-039 SRA 0x80000000 by OPERAND2=0x24 (amount 4) -> 0xF8000000, N=1; SRL same operands -> 0x08000000.
REQ-040 Back-to-back ADDs with OUT_READY low for 3 cycles -> first result held stable, IN_READY low for those 3 cycles, no result lost or duplicated.
REQ-041 MUL 7*6 -> 42, OUT_VALID first high 33 cycles after handshake, IN_READY low throughout.
REQ-041 also: a repeat MUL with RST_N pulsed at cycle 10 -> OUT_VALID never asserts.
REQ-041 also: without ALU_MUL_EN, MUL -> ALU_OUT=0, E=1, latency 1.
REQ-042 Opcode 13 -> ALU_OUT=0, E=1, Z=1.
